// File: rtl/regfile_param_sb_if.sv
// Decode/writeback-side bus of the miniRV integer register file: read ports,
// writeback, issue, clear control and debug read.
interface regfile_param_sb_if #(
    parameter int unsigned XLEN = 32
);
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic            rs1_busy;
    logic            rs2_busy;
    logic            reg_write;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] rd_data;
    logic            issue_valid;
    logic [4:0]      issue_rd;
    logic            clear_req;
    logic            clear_busy;
    logic [4:0]      dbg_addr;
    logic [XLEN-1:0] dbg_data;

    modport master (
        output rs1_addr, rs2_addr, reg_write, rd_addr, rd_data,
               issue_valid, issue_rd, clear_req, dbg_addr,
        input  rs1_val, rs2_val, rs1_busy, rs2_busy, clear_busy, dbg_data
    );

    modport slave (
        input  rs1_addr, rs2_addr, reg_write, rd_addr, rd_data,
               issue_valid, issue_rd, clear_req, dbg_addr,
        output rs1_val, rs2_val, rs1_busy, rs2_busy, clear_busy, dbg_data
    );
endinterface

// File: rtl/regfile_param_sb.sv
// Integer register file (x0 = 0) with pending-write scoreboard and clear sweep.
// Optional same-cycle write-to-read bypass: define REGFILE_BYPASS_EN.
module regfile_param_sb #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    regfile_param_sb_if.slave bus
);
    localparam int unsigned       NUM_REGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    typedef enum logic { IDLE, CLEAR } state_t;

    state_t            state;
    logic [ADDR_W-1:0] idx;
    logic              clear_busy_q;
    logic [XLEN-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;

    // Index must fit the implemented range and must not be x0.
    function automatic logic addr_ok(input logic [4:0] a);
        return ((a >> ADDR_W) == 5'd0) && (a != 5'd0);
    endfunction

    logic              wr_ok;
    logic              iss_ok;
    logic [ADDR_W-1:0] wr_idx;
    logic [ADDR_W-1:0] iss_idx;

    assign wr_ok   = bus.reg_write && addr_ok(bus.rd_addr);
    assign iss_ok  = bus.issue_valid && addr_ok(bus.issue_rd);
    assign wr_idx  = bus.rd_addr[ADDR_W-1:0];
    assign iss_idx = bus.issue_rd[ADDR_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            idx          <= '0;
            clear_busy_q <= 1'b0;
            busy         <= '0;
            for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (wr_ok) regs[wr_idx] <= bus.rd_data;
                    // Issue beats writeback: a newer producer is still pending.
                    for (int unsigned i = 1; i < NUM_REGS; i++) begin
                        if (iss_ok && iss_idx == ADDR_W'(i))
                            busy[i] <= 1'b1;
                        else if (wr_ok && wr_idx == ADDR_W'(i))
                            busy[i] <= 1'b0;
                    end
                    if (bus.clear_req) begin
                        state        <= CLEAR;
                        idx          <= ADDR_W'(1);
                        clear_busy_q <= 1'b1;
                    end
                end
                CLEAR: begin
                    regs[idx] <= '0;
                    busy[idx] <= 1'b0;
                    if (idx == LAST_IDX) begin
                        state        <= IDLE;
                        idx          <= '0;
                        clear_busy_q <= 1'b0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.clear_busy = clear_busy_q;

    always_comb begin
        bus.rs1_val  = addr_ok(bus.rs1_addr) ? regs[bus.rs1_addr[ADDR_W-1:0]] : '0;
        bus.rs2_val  = addr_ok(bus.rs2_addr) ? regs[bus.rs2_addr[ADDR_W-1:0]] : '0;
        bus.rs1_busy = addr_ok(bus.rs1_addr) ? busy[bus.rs1_addr[ADDR_W-1:0]] : 1'b0;
        bus.rs2_busy = addr_ok(bus.rs2_addr) ? busy[bus.rs2_addr[ADDR_W-1:0]] : 1'b0;
        bus.dbg_data = addr_ok(bus.dbg_addr) ? regs[bus.dbg_addr[ADDR_W-1:0]] : '0;
`ifdef REGFILE_BYPASS_EN
        if (wr_ok && state == IDLE && bus.rd_addr == bus.rs1_addr) begin
            bus.rs1_val  = bus.rd_data;
            bus.rs1_busy = iss_ok && (bus.issue_rd == bus.rs1_addr);
        end
        if (wr_ok && state == IDLE && bus.rd_addr == bus.rs2_addr) begin
            bus.rs2_val  = bus.rd_data;
            bus.rs2_busy = iss_ok && (bus.issue_rd == bus.rs2_addr);
        end
`endif
    end
endmodule

// File: tb/tb_regfile_param_sb.sv
// Scoreboard bench for regfile_param_sb (XLEN=32, ADDR_W=4).
module tb_regfile_param_sb;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_param_sb_if #(.XLEN(32)) bus ();

    regfile_param_sb #(.XLEN(32), .ADDR_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       tag;
        int          kind;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];

    // Reference state
    logic [31:0] m_regs [16];
    logic [15:0] m_busy;
    bit          m_clear;
    int          m_idx;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit idx_ok(input logic [4:0] a);
        return (a < 5'd16) && (a != 5'd0);
    endfunction

    function automatic logic [31:0] exp_val(input logic [4:0] a);
        if (!idx_ok(a)) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (!m_clear && bus.reg_write && idx_ok(bus.rd_addr) && bus.rd_addr == a)
            return bus.rd_data;
`endif
        return m_regs[a[3:0]];
    endfunction

    function automatic logic [31:0] exp_busy(input logic [4:0] a);
        if (!idx_ok(a)) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (!m_clear && bus.reg_write && idx_ok(bus.rd_addr) && bus.rd_addr == a)
            return {31'h0, bus.issue_valid && bus.issue_rd == a};
`endif
        return {31'h0, m_busy[a[3:0]]};
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = 32'h0;
        m_busy  = '0;
        m_clear = 1'b0;
        m_idx   = 0;
    endtask

    task automatic push(input string tag, input int kind, input logic [31:0] val);
        exp_t e;
        e.tag  = tag;
        e.kind = kind;
        e.val  = val;
        sb.push_back(e);
    endtask

    task automatic probe(input string tag, input logic [4:0] a1, input logic [4:0] a2,
                         input logic [4:0] ad);
        exp_t        e;
        logic [31:0] got;
        bus.rs1_addr = a1;
        bus.rs2_addr = a2;
        bus.dbg_addr = ad;
        push({tag, ".rs1_val"}, 0, exp_val(a1));
        push({tag, ".rs2_val"}, 1, exp_val(a2));
        push({tag, ".dbg"},     2, (idx_ok(ad) ? m_regs[ad[3:0]] : 32'h0));
        push({tag, ".rs1_busy"}, 3, exp_busy(a1));
        push({tag, ".rs2_busy"}, 4, exp_busy(a2));
        push({tag, ".clr_busy"}, 5, {31'h0, m_clear});
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.kind)
                0:       got = bus.rs1_val;
                1:       got = bus.rs2_val;
                2:       got = bus.dbg_data;
                3:       got = {31'h0, bus.rs1_busy};
                4:       got = {31'h0, bus.rs2_busy};
                default: got = {31'h0, bus.clear_busy};
            endcase
            check_eq(e.tag, got, e.val);
        end
    endtask

    task automatic idle_in();
        bus.reg_write   = 1'b0;
        bus.rd_addr     = 5'd0;
        bus.rd_data     = 32'h0;
        bus.issue_valid = 1'b0;
        bus.issue_rd    = 5'd0;
        bus.clear_req   = 1'b0;
    endtask

    // Advance one clock, updating the reference from the inputs seen at the edge.
    task automatic tick();
        logic [31:0] nr [16];
        logic [15:0] nb;
        bit          nc;
        int          ni;
        nr = m_regs;
        nb = m_busy;
        nc = m_clear;
        ni = m_idx;
        if (!m_clear) begin
            if (bus.reg_write && idx_ok(bus.rd_addr)) begin
                nr[bus.rd_addr[3:0]] = bus.rd_data;
                nb[bus.rd_addr[3:0]] = 1'b0;
            end
            if (bus.issue_valid && idx_ok(bus.issue_rd)) nb[bus.issue_rd[3:0]] = 1'b1;
            if (bus.clear_req) begin
                nc = 1'b1;
                ni = 1;
            end
        end else begin
            nr[m_idx] = 32'h0;
            nb[m_idx] = 1'b0;
            if (m_idx == 15) nc = 1'b0;
            else ni = m_idx + 1;
        end
        @(posedge clk);
        #1;
        m_regs  = nr;
        m_busy  = nb;
        m_clear = nc;
        m_idx   = ni;
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        bus.reg_write = 1'b1;
        bus.rd_addr   = a;
        bus.rd_data   = d;
        tick();
        idle_in();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        idle_in();
        bus.rs1_addr = 5'd0;
        bus.rs2_addr = 5'd0;
        bus.dbg_addr = 5'd0;
        m_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        probe("reset", 5'd1, 5'd2, 5'd3);

        // Asynchronous reset mid-cycle with live state
        write_reg(5'd1, 32'hA1);
        write_reg(5'd2, 32'hB2);
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd4;
        tick();
        idle_in();
        probe("pre_rst", 5'd1, 5'd4, 5'd2);
        #2 rst = 1'b1;
        m_reset();
        probe("async_rst", 5'd1, 5'd4, 5'd2);
        rst = 1'b0;

        // Write then read same cycle
        write_reg(5'd5, 32'h1111_1111);
        bus.reg_write = 1'b1;
        bus.rd_addr   = 5'd5;
        bus.rd_data   = 32'hDEAD_BEEF;
        probe("wr_same", 5'd5, 5'd6, 5'd5);
        tick();
        idle_in();
        probe("wr_next", 5'd5, 5'd6, 5'd5);

        // x0 and out-of-range writes are dropped
        write_reg(5'd0, 32'h1234);
        write_reg(5'd20, 32'h5678);
        probe("x0_inv", 5'd0, 5'd20, 5'd20);
        for (int i = 0; i < 16; i++) probe("keep", 5'(i), 5'(i), 5'(i));

        // Scoreboard priority
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd7;
        tick();
        idle_in();
        probe("sb_set", 5'd7, 5'd0, 5'd7);
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd7;
        bus.reg_write   = 1'b1;
        bus.rd_addr     = 5'd7;
        bus.rd_data     = 32'h77;
        tick();
        idle_in();
        probe("sb_both", 5'd7, 5'd7, 5'd7);
        write_reg(5'd7, 32'h78);
        probe("sb_clr", 5'd7, 5'd20, 5'd7);
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd20;
        tick();
        idle_in();
        probe("sb_inv", 5'd20, 5'd4, 5'd0);

        // Clear sweep, with a write committing in the request cycle
        for (int i = 1; i < 15; i++) write_reg(5'(i), 32'(i));
        bus.clear_req = 1'b1;
        bus.reg_write = 1'b1;
        bus.rd_addr   = 5'd15;
        bus.rd_data   = 32'hAA;
        tick();
        idle_in();
        n = 0;
        while (bus.clear_busy && n < 40) begin
            n++;
            if (n == 5) begin
                bus.reg_write   = 1'b1;
                bus.rd_addr     = 5'd2;
                bus.rd_data     = 32'hFFFF_FFFF;
                bus.issue_valid = 1'b1;
                bus.issue_rd    = 5'd9;
                bus.clear_req   = 1'b1;
            end
            probe("sweep", 5'(n), 5'd9, 5'd15);
            tick();
            idle_in();
        end
        check_eq("clr_len", 32'(n), 32'd15);
        for (int i = 0; i < 16; i++) probe("swept", 5'(i), 5'd9, 5'(i));

        // Reset during sweep cycle 6, then normal write
        for (int i = 1; i < 16; i++) write_reg(5'(i), 32'h100 + 32'(i));
        bus.clear_req = 1'b1;
        tick();
        idle_in();
        repeat (5) tick();
        probe("mid_sweep", 5'd6, 5'd7, 5'd5);
        #2 rst = 1'b1;
        m_reset();
        probe("sweep_rst", 5'd7, 5'd15, 5'd8);
        rst = 1'b0;
        write_reg(5'd3, 32'h33);
        probe("post_rst_wr", 5'd3, 5'd8, 5'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
